// File: rtl/schmidl_cox_preamble_inserter.sv
// Schmidl-Cox transmit preamble inserter: emits CP + two identical training halves from a
// preamble RAM ahead of each payload frame, then segments the stream into RFNoC packets.
module schmidl_cox_preamble_inserter #(
    parameter int HALF_FFT_SIZE = 512,
    parameter int HALF_CP_SIZE  = 64,
    parameter int ADDR_WIDTH    = $clog2(HALF_FFT_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [31:0]           packet_length,
    input  logic [15:0]           spp,
    input  logic                  pre_wr_en,
    input  logic [ADDR_WIDTH-1:0] pre_wr_addr,
    input  logic [31:0]           pre_wr_data,
    output logic                  pre_wr_err,
    input  logic [31:0]           i_tdata,
    input  logic                  i_tlast,
    input  logic                  i_tvalid,
    output logic                  i_tready,
    output logic [31:0]           o_tdata,
    output logic                  o_tlast,
    output logic                  o_tvalid,
    input  logic                  o_tready,
    output logic                  end_of_frame,
    output logic [15:0]           rfnoc_packet_length
);

    localparam int CP_LEN  = 2 * HALF_CP_SIZE;
    localparam int PRE_LEN = 2 * HALF_FFT_SIZE;
    localparam int CP_BASE = HALF_FFT_SIZE - CP_LEN;

    typedef enum logic [1:0] {S_IDLE, S_CP, S_PREAMBLE, S_PAYLOAD} state_t;

    state_t          state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [31:0]     plen_q;
    logic [15:0]     spp_q;
    logic [15:0]     push_idx_q;
    logic [15:0]     out_idx_q;
    logic [1:0]      fill_q, fill_d;
    logic            err_q;
    logic [31:0]     slot_data_q [2];
    logic [1:0]      slot_last_q;
    logic [1:0]      slot_eof_q;
    logic [31:0]     mem [HALF_FFT_SIZE];

    logic                  space;
    logic                  ram_rd;
    logic                  pay_rdy;
    logic                  pay_hs;
    logic                  frame_end;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  push;
    logic                  push_last;
    logic                  pop;
    logic                  unused_tlast;

    assign unused_tlast = i_tlast;

    // Space is judged on fill alone so i_tready never depends combinationally on o_tready;
    // at full throughput the skid holds a single beat, so this costs no bubbles.
    assign space     = (fill_q != 2'd2);
    assign pay_hs    = pay_rdy & i_tvalid;
    assign push      = ram_rd | pay_hs;
    assign push_last = frame_end | ((spp_q != 16'd0) && (push_idx_q == spp_q));
    assign pop       = (fill_q != 2'd0) & o_tready;
    assign fill_d    = fill_q + {1'b0, push} - {1'b0, pop};

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (i_tvalid) begin
                    state_d = S_CP;
                    cnt_d   = '0;
                end
            end
            S_CP: begin
                if (ram_rd) begin
                    if (cnt_q == 32'(CP_LEN - 1)) begin
                        state_d = S_PREAMBLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            S_PREAMBLE: begin
                if (ram_rd) begin
                    if (cnt_q == 32'(PRE_LEN - 1)) begin
                        state_d = (plen_q == 32'd0) ? S_IDLE : S_PAYLOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (pay_hs) begin
                    if (frame_end) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs (RAM read issue, payload ready, end-of-frame tagging)
    always_comb begin
        ram_rd    = 1'b0;
        pay_rdy   = 1'b0;
        frame_end = 1'b0;
        rd_addr   = '0;
        case (state_q)
            S_CP: begin
                ram_rd  = space;
                rd_addr = ADDR_WIDTH'(32'(CP_BASE) + cnt_q);
            end
            S_PREAMBLE: begin
                ram_rd    = space;
                rd_addr   = ADDR_WIDTH'((cnt_q >= 32'(HALF_FFT_SIZE)) ?
                                        (cnt_q - 32'(HALF_FFT_SIZE)) : cnt_q);
                frame_end = (cnt_q == 32'(PRE_LEN - 1)) && (plen_q == 32'd0);
            end
            S_PAYLOAD: begin
                pay_rdy   = space;
                frame_end = (cnt_q == plen_q - 32'd1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plen_q     <= '0;
            spp_q      <= '0;
            push_idx_q <= 16'd1;
            out_idx_q  <= 16'd1;
            fill_q     <= '0;
            err_q      <= 1'b0;
        end else if (clear) begin
            plen_q     <= '0;
            spp_q      <= '0;
            push_idx_q <= 16'd1;
            out_idx_q  <= 16'd1;
            fill_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == S_IDLE && i_tvalid) begin
                plen_q <= packet_length;
                spp_q  <= spp;
            end
            if (push) begin
                push_idx_q <= push_last ? 16'd1 : push_idx_q + 16'd1;
            end
            if (pop) begin
                out_idx_q <= slot_last_q[0] ? 16'd1 : out_idx_q + 16'd1;
            end
            fill_q <= fill_d;
            err_q  <= pre_wr_en && (state_q != S_IDLE);
        end
    end

    // Skid slots: slot 0 is the head; the RAM read lands here directly, giving 1-cycle read latency.
    always_ff @(posedge clk) begin
        if (push && (fill_q == 2'd0 || (fill_q == 2'd1 && pop))) begin
            slot_data_q[0] <= ram_rd ? mem[rd_addr] : i_tdata;
            slot_last_q[0] <= push_last;
            slot_eof_q[0]  <= frame_end;
        end else if (pop && fill_q == 2'd2) begin
            slot_data_q[0] <= slot_data_q[1];
            slot_last_q[0] <= slot_last_q[1];
            slot_eof_q[0]  <= slot_eof_q[1];
        end
        if (push && fill_q == 2'd1 && !pop) begin
            slot_data_q[1] <= ram_rd ? mem[rd_addr] : i_tdata;
            slot_last_q[1] <= push_last;
            slot_eof_q[1]  <= frame_end;
        end
    end

    always_ff @(posedge clk) begin
        if (pre_wr_en && state_q == S_IDLE) begin
            mem[pre_wr_addr] <= pre_wr_data;
        end
    end

    assign o_tvalid            = (fill_q != 2'd0);
    assign o_tdata             = o_tvalid ? slot_data_q[0] : 32'd0;
    assign o_tlast             = o_tvalid & slot_last_q[0];
    assign end_of_frame        = pop & slot_eof_q[0];
    assign i_tready            = pay_rdy;
    assign pre_wr_err          = err_q;
    assign rfnoc_packet_length = out_idx_q;

endmodule

// File: tb/tb_schmidl_cox_preamble_inserter.sv
// Bench for schmidl_cox_preamble_inserter: table of frame configurations plus randomized
// frames, each checked beat by beat against a frame model built from the buffer contents.
module tb_schmidl_cox_preamble_inserter;

    localparam int HF  = 8;
    localparam int HCP = 2;

    logic        clk = 1'b0;
    logic        reset, clear;
    logic [31:0] packet_length;
    logic [15:0] spp;
    logic        pre_wr_en;
    logic [2:0]  pre_wr_addr;
    logic [31:0] pre_wr_data;
    logic        pre_wr_err;
    logic [31:0] i_tdata;
    logic        i_tlast, i_tvalid, i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast, o_tvalid, o_tready;
    logic        end_of_frame;
    logic [15:0] rfnoc_packet_length;

    int checks = 0;
    int errors = 0;
    logic [31:0] bufm [HF];

    schmidl_cox_preamble_inserter #(.HALF_FFT_SIZE(HF), .HALF_CP_SIZE(HCP)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .packet_length(packet_length), .spp(spp),
        .pre_wr_en(pre_wr_en), .pre_wr_addr(pre_wr_addr), .pre_wr_data(pre_wr_data),
        .pre_wr_err(pre_wr_err),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .end_of_frame(end_of_frame), .rfnoc_packet_length(rfnoc_packet_length)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr_buf(input int addr, input logic [31:0] data);
        pre_wr_en   = 1'b1;
        pre_wr_addr = 3'(addr);
        pre_wr_data = data;
        @(posedge clk); #1;
        pre_wr_en = 1'b0;
        bufm[addr] = data;
    endtask

    task automatic run_frame(input int p_len, input int p_spp, input int rdy, input int ivld,
                             input int wr_beat, output int nbeats, output int nlasts,
                             output int span);
        logic [31:0] ed[$];
        bit          el[$];
        int          ex[$];
        logic [31:0] pay[$];
        int n, idx, pi, bi, eofs, ins, cyc, wr_phase, first_cyc, last_cyc;
        bit last, in_hs, prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;

        for (int k = 0; k < p_len; k++) pay.push_back($urandom);
        for (int k = 0; k < 2 * HCP; k++) ed.push_back(bufm[HF - 2 * HCP + k]);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < HF; k++) ed.push_back(bufm[k]);
        for (int k = 0; k < p_len; k++) ed.push_back(pay[k]);
        n = ed.size();
        idx = 1;
        for (int j = 0; j < n; j++) begin
            last = (j == n - 1) || (p_spp != 0 && idx == p_spp);
            el.push_back(last);
            ex.push_back(idx);
            idx = last ? 1 : idx + 1;
        end

        pi = 0; bi = 0; eofs = 0; ins = 0; cyc = 0; wr_phase = 0;
        first_cyc = 0; last_cyc = 0; nlasts = 0; prev_stall = 0;
        prev_data = '0; prev_last = 1'b0;
        packet_length = 32'(p_len);
        spp           = 16'(p_spp);
        i_tvalid      = 1'b1;
        i_tdata       = (p_len > 0) ? pay[0] : 32'h0;
        o_tready      = ($urandom_range(0, 99) < rdy);

        while (bi < n && cyc < 2000) begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stall data stable", o_tdata, prev_data);
                chk("stall last stable", {31'd0, o_tlast}, {31'd0, prev_last});
            end
            if (o_tvalid && o_tready) begin
                chk($sformatf("beat%0d data", bi), o_tdata, ed[bi]);
                chk($sformatf("beat%0d tlast", bi), {31'd0, o_tlast}, {31'd0, el[bi]});
                chk($sformatf("beat%0d pktlen", bi), {16'd0, rfnoc_packet_length}, 32'(ex[bi]));
                chk($sformatf("beat%0d eof", bi), {31'd0, end_of_frame}, {31'd0, bi == n - 1});
                if (bi == 0) first_cyc = cyc;
                last_cyc = cyc;
                if (o_tlast) nlasts++;
                if (end_of_frame) eofs++;
                bi++;
            end
            prev_stall = o_tvalid && !o_tready;
            prev_data  = o_tdata;
            prev_last  = o_tlast;
            in_hs      = i_tvalid && i_tready;
            @(posedge clk); #1;
            cyc++;
            if (in_hs) begin
                ins++;
                pi++;
            end
            if (pi < p_len) begin
                i_tdata = pay[pi];
                if (in_hs || !i_tvalid) i_tvalid = ($urandom_range(0, 99) < ivld);
            end else begin
                i_tvalid = 1'b0;
            end
            o_tready = ($urandom_range(0, 99) < rdy);
            if (wr_beat >= 0) begin
                case (wr_phase)
                    0: if (bi >= wr_beat) begin
                        pre_wr_en   = 1'b1;
                        pre_wr_addr = 3'd0;
                        pre_wr_data = 32'hBAD0_0000;
                        wr_phase    = 1;
                    end
                    1: begin
                        pre_wr_en = 1'b0;
                        chk("pre_wr_err pulse", {31'd0, pre_wr_err}, 32'd1);
                        wr_phase = 2;
                    end
                    2: begin
                        chk("pre_wr_err one cycle", {31'd0, pre_wr_err}, 32'd0);
                        wr_phase = 3;
                    end
                    default: ;
                endcase
            end
        end
        pre_wr_en = 1'b0;
        if (cyc >= 2000) chk("frame timeout beats", 32'(bi), 32'(n));
        chk("eof count", 32'(eofs), 32'd1);
        chk("payload accepted", 32'(ins), 32'(p_len));
        o_tready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("idle after frame", {31'd0, o_tvalid}, 32'd0);
        end
        @(posedge clk); #1;
        nbeats = bi;
        span   = last_cyc - first_cyc;
    endtask

    typedef struct {
        int plen; int spp; int rdy; int ivld; int wr_beat;
        int beats; int lasts; int span;
    } vec_t;
    vec_t tv[7];

    initial begin
        int nb, nl, sp, hs, eofs, cyc;

        tv[0] = '{3, 0, 100, 100, -1, 23, 1, 22};
        tv[1] = '{3, 10, 100, 100, -1, 23, 3, 22};
        tv[2] = '{0, 0, 100, 100, -1, 20, 1, 19};
        tv[3] = '{5, 0, 50, 100, -1, 25, 1, -1};
        tv[4] = '{5, 7, 60, 70, 8, 25, 4, -1};
        tv[5] = '{1, 1, 100, 100, -1, 21, 21, 20};
        tv[6] = '{6, 4, 100, 60, -1, 26, 7, -1};

        reset = 1'b1; clear = 1'b0; packet_length = 32'd3; spp = 16'd0;
        pre_wr_en = 1'b0; pre_wr_addr = 3'd0; pre_wr_data = 32'd0;
        i_tdata = 32'd0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("reset o_tvalid", {31'd0, o_tvalid}, 32'd0);
        chk("reset o_tlast", {31'd0, o_tlast}, 32'd0);
        chk("reset o_tdata", o_tdata, 32'd0);
        chk("reset i_tready", {31'd0, i_tready}, 32'd0);
        chk("reset eof", {31'd0, end_of_frame}, 32'd0);
        chk("reset pre_wr_err", {31'd0, pre_wr_err}, 32'd0);
        chk("reset pktlen", {16'd0, rfnoc_packet_length}, 32'd1);

        for (int k = 0; k < HF; k++) wr_buf(k, 32'h100 + 32'(k));
        chk("idle write no err", {31'd0, pre_wr_err}, 32'd0);

        // Latency, then abort with clear after 12 beats
        i_tvalid = 1'b1;
        i_tdata  = 32'hA0;
        @(posedge clk); #1;
        chk("latency cycle1 no valid", {31'd0, o_tvalid}, 32'd0);
        @(posedge clk); #1;
        chk("latency cycle2 valid", {31'd0, o_tvalid}, 32'd1);
        chk("first beat data", o_tdata, 32'h104);
        hs = 0; eofs = 0; cyc = 0;
        while (hs < 12 && cyc < 100) begin
            @(negedge clk);
            if (o_tvalid && o_tready) hs++;
            if (end_of_frame) eofs++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("beats before clear", 32'(hs), 32'd12);
        clear    = 1'b1;
        i_tvalid = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear o_tvalid", {31'd0, o_tvalid}, 32'd0);
        chk("clear o_tdata", o_tdata, 32'd0);
        chk("clear o_tlast", {31'd0, o_tlast}, 32'd0);
        chk("clear i_tready", {31'd0, i_tready}, 32'd0);
        chk("clear eof", {31'd0, end_of_frame}, 32'd0);
        chk("clear pktlen", {16'd0, rfnoc_packet_length}, 32'd1);
        chk("no eof in aborted frame", 32'(eofs), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_frame(tv[i].plen, tv[i].spp, tv[i].rdy, tv[i].ivld, tv[i].wr_beat, nb, nl, sp);
            chk($sformatf("row%0d beats", i), 32'(nb), 32'(tv[i].beats));
            chk($sformatf("row%0d tlasts", i), 32'(nl), 32'(tv[i].lasts));
            if (tv[i].span >= 0) chk($sformatf("row%0d span", i), 32'(sp), 32'(tv[i].span));
        end

        for (int f = 0; f < 6; f++) begin
            wr_buf($urandom_range(0, HF - 1), $urandom);
            wr_buf($urandom_range(0, HF - 1), $urandom);
            run_frame($urandom_range(0, 12), $urandom_range(0, 9), $urandom_range(30, 100),
                      $urandom_range(30, 100), -1, nb, nl, sp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
